// File: rtl/ads868x_scan.sv
// ads868x_scan: scans 32 ADS868x channels (4 internal x 8 external mux) and streams tagged results over AXI4-Stream
// Ports:
//   aclk, aresetn             clock, synchronous active-low reset
//   trig, cont_en             single scan request, automatic rescan enable
//   m_axis_tdata/tvalid/tready  result stream {8'h00, id[7:0], data[15:0]}; marker 32'h00FF_0000 opens each scan
//   spi_cs_n/sclk/mosi/miso   ADS868x SPI master (mode 0, 32-bit frames)
//   ext_mux                   external 8:1 mux select (id[4:2])
//   busy                      scan in progress
//   overflow, clr_overflow    sticky dropped-word flag and its clear
module ads868x_scan #(
    parameter int SCLK_DIV       = 2,
    parameter int SETTLE_CYCLES  = 250,
    parameter int CS_HIGH_CYCLES = 8
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        trig,
    input  logic        cont_en,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [2:0]  ext_mux,
    output logic        busy,
    output logic        overflow,
    input  logic        clr_overflow
);
    typedef enum logic [2:0] {IDLE, MARKER, SETTLE, XFER, GAP, DONE} state_t;
    state_t state, state_n;
    logic [31:0] cnt;
    logic [5:0]  h;
    logic [5:0]  k;
    logic [5:0]  k_inc;
    logic [31:0] sh;
    logic [15:0] rx;
    logic [15:0] cmd;
    logic [7:0]  pid;
    logic        pend;
    logic        bit_tick;
    logic        frame_end;
    logic        to_settle;
    logic        push;
    logic [31:0] word;
    always_comb begin
        bit_tick  = cnt == 32'(SCLK_DIV - 1);
        frame_end = state == XFER && bit_tick && h == 6'd63;
        k_inc     = k + 6'd1;
        // frames 4,8,..,28 get a mux settle; frame 32 (NO_OP) only a CS gap
        to_settle = k[1:0] == 2'd3 && k != 6'd31;
        cmd       = k[5] ? 16'h0000 : {4'hC, k[1:0], 10'h000};
        push      = state == MARKER || pend;
        word      = state == MARKER ? 32'h00FF_0000 : {8'h00, pid, rx};
        state_n   = state;
        case (state)
            IDLE:    state_n = trig ? MARKER : IDLE;
            MARKER:  state_n = SETTLE;
            SETTLE:  state_n = cnt == 32'(SETTLE_CYCLES - 1) ? XFER : SETTLE;
            XFER:    state_n = !frame_end ? XFER : k == 6'd32 ? DONE : to_settle ? SETTLE : GAP;
            GAP:     state_n = cnt == 32'(CS_HIGH_CYCLES - 1) ? XFER : GAP;
            DONE:    state_n = cont_en ? MARKER : IDLE;
            default: state_n = IDLE;
        endcase
    end
    // h counts SCLK half-periods within a frame: even = SCLK low, odd = SCLK high
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= IDLE;
            cnt           <= '0;
            h             <= '0;
            k             <= '0;
            sh            <= '0;
            rx            <= '0;
            pid           <= '0;
            pend          <= 1'b0;
            ext_mux       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state || (state == XFER && bit_tick)) ? '0 : cnt + 32'd1;
            // frame 0 returns stale data from before the scan; nothing is emitted for it
            pend  <= frame_end && k != 6'd0;
            if (state == MARKER) begin
                k       <= '0;
                ext_mux <= '0;
            end
            if (state != XFER && state_n == XFER) begin
                h  <= '0;
                sh <= {cmd, 16'h0000};
            end else if (state == XFER && bit_tick) begin
                h <= h + 6'd1;
                if (h[0])
                    sh <= {sh[30:0], 1'b0};
                if (!h[0] && h[5])
                    rx <= {rx[14:0], spi_miso};
            end
            if (frame_end) begin
                k   <= k_inc;
                pid <= {2'b00, k - 6'd1};
                if (to_settle)
                    ext_mux <= k_inc[4:2];
            end
            // single-entry output: a word arriving while the held one is stalled is dropped
            if (push && (!m_axis_tvalid || m_axis_tready)) begin
                m_axis_tdata  <= word;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (push && m_axis_tvalid && !m_axis_tready)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;
        end
    end
    assign busy     = state != IDLE;
    assign spi_cs_n = state != XFER;
    assign spi_sclk = state == XFER && h[0];
    assign spi_mosi = state == XFER && sh[31];
endmodule

// File: doc/ads868x_scan.md
ADS868X_SCAN -- requirements
Module: ads868x_scan

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 2, aclk cycles per SCLK half-period (min 1).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 250, external-mux settle wait in aclk cycles (min 1).
REQ-003 SHALL have parameter CS_HIGH_CYCLES, default 8, CS_N high gap between frames in aclk cycles (min 1).
REQ-004 aclk  in  1  sole clock; all logic on rising edge.
REQ-005 aresetn  in  1  reset, synchronous, active-low.
REQ-006 trig  in  1  single-cycle scan start request.
REQ-007 cont_en  in  1  1 = restart scan automatically after each scan.
REQ-008 m_axis_tdata  out  32  {8'h00, channel ID[7:0], ADC data[15:0]}.
REQ-009 m_axis_tvalid  out  1 / m_axis_tready  in  1  AXI4-Stream handshake.
REQ-010 spi_cs_n, spi_sclk, spi_mosi  out  1 each  ADS868x SPI master.
REQ-011 spi_miso  in  1  ADS868x serial data.
REQ-012 ext_mux  out  3  external 8:1 mux select (= ID[4:2]).
REQ-013 busy  out  1  scan in progress.
REQ-014 overflow  out  1 / clr_overflow  in  1  sticky drop flag and its clear.

Function
REQ-015 Scan SHALL start from IDLE on trig=1, or on scan completion when cont_en=1; trig while busy SHALL be ignored.
REQ-016 Scan SHALL first emit marker word 32'h00FF_0000, then 32 data words with IDs 0..31 ascending.
REQ-017 States: IDLE -> MARKER -> SETTLE -> XFER -> (GAP -> XFER | SETTLE) ... -> DONE -> IDLE or MARKER (cont_en).
REQ-018 Scan SHALL contain 33 SPI frames k=0..32; frame k<32 sends MAN_Ch command 16'hC000 | (k[1:0] << 10); frame 32 sends 16'h0000 (NO_OP).
REQ-019 Data read in frame k (k>=1) SHALL be tagged ID k-1; data from frame 0 SHALL be discarded.
REQ-020 ext_mux SHALL update to k[4:2] at entry to SETTLE before frames k = 0,4,...,28; SETTLE lasts SETTLE_CYCLES with CS_N high; other frames preceded by GAP of CS_HIGH_CYCLES.
REQ-021 Frame: CS_N low, 32 SCLK periods, SCLK idle low, period 2*SCLK_DIV aclk; MOSI changes on SCLK falling edge, bits 31..16 = command MSB first, bits 15..0 = 0; first bit valid when CS_N falls.
REQ-022 MISO SHALL be sampled on SCLK rising edges 17..32, MSB first, forming the 16-bit result.
REQ-023 CS_N SHALL rise one SCLK half-period after the 32nd rising edge.
REQ-024 Result word SHALL load the output register in the cycle after CS_N rises; tvalid held until tready.
REQ-025 Output register SHALL be single-entry; if a new word (marker or data) is ready while tvalid=1 and tready=0, the new word SHALL be dropped and overflow set; scan timing SHALL never stall.
REQ-026 overflow SHALL stay 1 until clr_overflow=1; set and clear in same cycle SHALL leave overflow=1.
REQ-027 busy SHALL be 1 from MARKER entry to DONE exit inclusive.
REQ-028 tdata[31:24] SHALL always be 0.

Reset
REQ-029 On aresetn=0 at an edge: state IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, ext_mux=0, m_axis_tvalid=0, m_axis_tdata=0, busy=0, overflow=0.
REQ-030 Reset mid-frame SHALL abort the frame with CS_N high the next cycle; no partial word SHALL be emitted.

Verification
REQ-031 tready=1, trig pulse, ADC model returns 16'h1000+ID -> marker 32'h00FF_0000 then 32 words 32'h0000_1000..32'h001F_101F in order, overflow=0.
REQ-032 SCLK_DIV=2 -> SCLK period 4 aclk, exactly 32 SCLK per frame, MOSI frame 5 = 16'hC400, frame 32 = 16'h0000.
REQ-033 Check ext_mux: 0 for IDs 0-3 commands, 7 for 28-31; SETTLE gap = 250 cycles before frames 0,4,..,28, CS gap = 8 elsewhere.
REQ-034 tready=0 throughout scan -> only marker held (tvalid=1, 32'h00FF_0000), overflow=1; clr_overflow -> 0.
REQ-035 cont_en=1 -> second marker follows ID 31 word without trig; trig during scan -> no extra marker.
REQ-036 aresetn=0 during frame 10 -> CS_N=1 next cycle, tvalid=0, busy=0, no further words.
